// File: rtl/ev22_regbank_pkg.sv
// Shared definitions for the register-bank write arbiter: register index
// constants, the write-legality rule and the arbiter state type.
package ev22_regbank_pkg;

    localparam logic [5:0] REG_PI0  = 6'd28;  // input port, read-only
    localparam logic [5:0] REG_PI1  = 6'd29;  // input port, read-only
    localparam logic [5:0] REG_PO0  = 6'd30;
    localparam logic [5:0] REG_PO1  = 6'd31;
    localparam logic [5:0] REG_W    = 6'd34;  // working register, loadable from memory
    localparam logic [5:0] SEL_IDLE = 6'd63;  // matches no bank register

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Writable: general registers 0..27, the two output ports, and W.
    function automatic logic sel_is_writable(input logic [5:0] sel);
        return (sel <= 6'd27) || (sel == REG_PO0) || (sel == REG_PO1) || (sel == REG_W);
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    // Scan NREQ positions starting at ptr; the first requester found wins.
    always_comb begin
        logic found;
        int   j;
        // NOTE: every combinational output gets a default before the scan so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register-bank write port among NREQ requesters with
// round-robin arbitration, optional burst lock, illegal-index filtering
// and one registered output stage.
// Optional feature macro: REGARB_ERRCNT_EN adds err_cnt (saturating count
// of illegal writes).
module regbank_write_arbiter
    import ev22_regbank_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int DW       = 16,
    parameter int SW       = 6,
    parameter int IDLE_SEL = 63
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*SW-1:0] req_sel,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_mem,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    req_ready,
    output logic [SW-1:0]      Sel_C,
    output logic [DW-1:0]      Data_C,
    output logic               MR,
    output logic               wr_err,
    output logic [SW-1:0]      err_sel
`ifdef REGARB_ERRCNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, next_state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   lock_owner;
    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] owner_mask;
    logic [PW-1:0]   win_idx;
    logic            accept;
    logic [SW-1:0]   win_sel;
    logic [DW-1:0]   win_data;
    logic            win_mem;
    logic            win_lock;
    logic            win_legal;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Decode the lock owner to a one-hot mask.
    always_comb begin
        owner_mask             = '0;
        owner_mask[lock_owner] = 1'b1;
    end

    // Select the winner's request fields; in LOCKED the owner is the only candidate.
    always_comb begin
        win_idx   = (state == LOCKED) ? lock_owner : pick_idx;
        accept    = |req_ready;
        win_sel   = req_sel[int'(win_idx)*SW +: SW];
        win_data  = req_data[int'(win_idx)*DW +: DW];
        win_mem   = req_mem[win_idx];
        win_lock  = req_lock[win_idx];
        win_legal = sel_is_writable(6'(win_sel));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!nreset) state <= ARB;
        else         state <= next_state;
    end

    // FSM next state: enter LOCKED on a locked beat, leave on an unlocked beat or when the owner goes idle.
    always_comb begin
        next_state = state;
        case (state)
            ARB:    if (accept && win_lock) next_state = LOCKED;
            LOCKED: if (!req_valid[lock_owner] || (accept && !win_lock)) next_state = ARB;
            default: next_state = ARB;
        endcase
    end

    // FSM output: one-hot ready, only ever for a valid requester.
    always_comb begin
        case (state)
            LOCKED:  req_ready = req_valid & owner_mask;
            default: req_ready = pick_grant;
        endcase
    end

    // Round-robin pointer advances past each ARB winner; lock owner captured on a locked ARB grant.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rr_ptr     <= '0;
            lock_owner <= '0;
        end else if (accept && state == ARB) begin
            rr_ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            if (win_lock) lock_owner <= win_idx;
        end
    end

    // Output stage: issue legal writes, replace illegal ones with the idle select and flag them.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            Sel_C   <= SW'(IDLE_SEL);
            Data_C  <= '0;
            MR      <= 1'b0;
            wr_err  <= 1'b0;
            err_sel <= '0;
        end else begin
            Sel_C  <= SW'(IDLE_SEL);
            MR     <= 1'b0;
            wr_err <= 1'b0;
            if (accept) begin
                Data_C <= win_data;
                if (win_legal) begin
                    Sel_C <= win_sel;
                    MR    <= win_mem && (win_sel == SW'(REG_W));
                end else begin
                    wr_err  <= 1'b1;
                    err_sel <= win_sel;
                end
            end
        end
    end

`ifdef REGARB_ERRCNT_EN
    // Saturating count of illegal writes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                                         err_cnt <= '0;
        else if (accept && !win_legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule
